hall_call_dispatcher: RTL
=========================

// Module: hall_call_dispatcher
// PURPOSE
//   Dispatches latched hall calls to the left or right car.
//   Sits upstream of the DirectionScoringSystem and drives its FloorDestinations and FloorsRequested inputs.
//   Each pending floor gets a distance/direction cost, computed sequentially one call at a time.
//   The call goes to the cheaper car. A destination bit clears when that car arrives at the floor.
// PARAMETERS
//   NUM_FLOORS  6  floors per car; positions are in half-floor units, floor f == position 2f
//   POS_W       4  width of one car's half-floor position field
//   COST_W      5  width of cost registers; must hold 2*(NUM_FLOORS-1) + 2*NUM_FLOORS
// PORTS
//   clk                     in   1             system clock
//   rst                     in   1             reset; synchronous, active-low
//   simState                in   2             00 HALT, 01 RUN, 10/11 HOLD
//   hall_req                in   NUM_FLOORS    hall-call button pulses, bit f = floor f
//   half_elevatorPositions  in   2*POS_W       [3:0] left car, [7:4] right car
//   directions              in   2             per-car travel direction, 1 = up; bit 1 = right car
//   arrived                 in   2             1-cycle pulse: car stopped with doors open; bit 1 = right
//   FloorDestinations       out  2*NUM_FLOORS  [5:0] left-car stops, [11:6] right-car stops
//   FloorsRequested         out  NUM_FLOORS    latched calls not yet assigned
//   assign_valid            out  1             1-cycle pulse when a call is assigned
//   assign_car              out  1             car of the last assignment (0 left, 1 right)
//   assign_floor            out  3             floor of the last assignment
//   busy                    out  1             FSM not in IDLE
// BEHAVIOUR
// - Reset (rst==0 at a clk edge): all outputs 0, FSM = IDLE, scan pointer = 0.
// - Latch: pend <= pend | hall_req, except floors already set in either car's FloorDestinations.
//   Latching runs in RUN and HOLD.
//   FloorsRequested = pend.
// - FSM (advances only in RUN):
//   IDLE  -> SCAN when pend != 0.
//   SCAN: picks the first set pend bit at or above ptr, wrapping modulo NUM_FLOORS.
//   SCAN -> SCORE, holding the target floor f.
//   SCORE: registers costL and costR.
//     cost = |pos - 2f| + (moving_away ? 2*NUM_FLOORS : 0).
//     moving_away = car has any destination bit set AND (dir up AND 2f < pos, OR dir down AND 2f > pos).
//     Cars with no destinations never take the penalty.
//   SCORE -> ASSIGN.
//   ASSIGN: winner = right iff costR < costL (tie goes to left).
//     Sets FloorDestinations[winner*NUM_FLOORS + f] and clears pend[f].
//     Pulses assign_valid and updates assign_car/assign_floor.
//     ptr <= (f+1) mod NUM_FLOORS. ASSIGN -> IDLE.
// - Latency: hall_req sampled at edge k with FSM idle -> FloorDestinations bit set after edge k+4.
//   Throughput is one assignment per 4 cycles.
// - Position > 2*(NUM_FLOORS-1) is clamped to 2*(NUM_FLOORS-1). Arithmetic is unsigned, COST_W bits.
// - Arrival: arrived[c] with pos even and dest bit (c, pos/2) set -> that bit clears next edge.
//   Clearing applies in RUN and HOLD.
// - Simultaneous events:
//   * arrival clear and ASSIGN on the same bit: clear wins.
//   * hall_req[f] while either car arrives at floor f: the request is absorbed (not latched).
//   * hall_req[f] arriving during SCORE/ASSIGN of floor f: merged, not re-queued.
// - HOLD (10/11): FSM freezes in its current state. Outputs hold, except latch/clear updates.
//   assign_valid stays 0 while frozen.
// - HALT (00): next edge clears pend and FloorDestinations; FSM returns to IDLE; hall_req ignored.
// - Reset asserted mid-SCAN/SCORE/ASSIGN: no partial assignment; all state returns to reset values.
// TESTING
// - Left pos 0, right pos 10, both idle, hall_req=6'b010000 -> after 4 edges
//   FloorDestinations=12'h400, assign_car=1, assign_floor=4.
// - Both cars at pos 4, idle, hall_req floor 2 -> tie, left wins, FloorDestinations=12'h004.
// - Left pos 2, dir up, dest floor 5 (12'h020); right pos 10 idle; hall_req floor 0
//   -> costL=14, costR=10 -> bit 6 set, FloorDestinations=12'h060.
// - FloorDestinations=12'h010, left pos 8, arrived=2'b01 for one cycle
//   -> next edge FloorDestinations=12'h000.
// - hall_req floors 1 and 3 in the same cycle, ptr=0 -> floor 1 assigned at k+4, floor 3 at k+8;
//   FloorsRequested steps 6'b001010 -> 6'b001000 -> 0.
// - simState=10 with hall_req floor 5 -> FloorsRequested=6'b100000 and no assign_valid for 20 cycles;
//   set 01 -> assigned within 4 edges. rst=0 during SCORE -> all outputs 0 next edge.

Source files
------------

// File: rtl/hall_call_dispatcher.sv
// Latches hall calls and hands each to the cheaper car, one call per 4 cycles (IDLE/SCAN/SCORE/ASSIGN).
// A call sampled while idle lands in FloorDestinations 4 edges later; HOLD freezes the FSM but keeps latching.
module hall_call_dispatcher #(
  parameter  int NUM_FLOORS = 6,
  parameter  int POS_W      = 4,
  parameter  int COST_W     = 5,
  localparam int FLR_W      = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              simState,
  input  logic [NUM_FLOORS-1:0]   hall_req,
  input  logic [2*POS_W-1:0]      half_elevatorPositions,
  input  logic [1:0]              directions,
  input  logic [1:0]              arrived,
  output logic [2*NUM_FLOORS-1:0] FloorDestinations,
  output logic [NUM_FLOORS-1:0]   FloorsRequested,
  output logic                    assign_valid,
  output logic                    assign_car,
  output logic [FLR_W-1:0]        assign_floor,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    SCORE  = 2'd2,
    ASSIGN = 2'd3
  } state_t;

  localparam logic [POS_W-1:0]  POS_MAX = POS_W'(2 * (NUM_FLOORS - 1));
  localparam logic [COST_W-1:0] AWAY_PENALTY = COST_W'(2 * NUM_FLOORS);

  state_t                  state_q, state_d;
  logic [NUM_FLOORS-1:0]   pend_q, pend_d;
  logic [2*NUM_FLOORS-1:0] dest_q, dest_d;
  logic [FLR_W-1:0]        ptr_q, ptr_d;
  logic [FLR_W-1:0]        tgt_q, tgt_d;
  logic [COST_W-1:0]       cost_l_q, cost_l_d;
  logic [COST_W-1:0]       cost_r_q, cost_r_d;
  logic                    av_q, av_d;
  logic                    acar_q, acar_d;
  logic [FLR_W-1:0]        afloor_q, afloor_d;

  logic [POS_W-1:0]        pos_l, pos_r;
  logic                    run, halt;
  logic                    scan_hit;
  logic [FLR_W-1:0]        scan_idx;
  logic [NUM_FLOORS-1:0]   arr_l, arr_r;
  logic [NUM_FLOORS-1:0]   new_req;
  logic [NUM_FLOORS-1:0]   tgt_mask;
  logic [NUM_FLOORS-1:0]   pend_clr;
  logic [2*NUM_FLOORS-1:0] set_mask;
  logic                    win_r;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] p);
    clamp_pos = (p > POS_MAX) ? POS_MAX : p;
  endfunction

  // Distance to the floor, plus a penalty when a busy car is heading away from it.
  function automatic logic [COST_W-1:0] car_cost(
    input logic [POS_W-1:0] pos,
    input logic [FLR_W-1:0] f,
    input logic             up,
    input logic             has_dest
  );
    logic [COST_W-1:0] p;
    logic [COST_W-1:0] t;
    logic [COST_W-1:0] d;
    logic              away;
    p    = COST_W'(pos);
    t    = COST_W'(f) << 1;
    d    = (p >= t) ? (p - t) : (t - p);
    away = has_dest && ((up && (t < p)) || (!up && (t > p)));
    car_cost = d + (away ? AWAY_PENALTY : '0);
  endfunction

  // Only an even (at-floor) position inside the shaft counts as an arrival.
  function automatic logic [NUM_FLOORS-1:0] arrive_mask(
    input logic [POS_W-1:0] pos,
    input logic             arr
  );
    arrive_mask = '0;
    if (arr && !pos[0] && (int'(pos >> 1) < NUM_FLOORS)) begin
      arrive_mask = NUM_FLOORS'(1) << (pos >> 1);
    end
  endfunction

  assign pos_l = clamp_pos(half_elevatorPositions[POS_W-1:0]);
  assign pos_r = clamp_pos(half_elevatorPositions[2*POS_W-1:POS_W]);
  assign run   = (simState == 2'b01);
  assign halt  = (simState == 2'b00);
  assign arr_l = arrive_mask(half_elevatorPositions[POS_W-1:0], arrived[0]);
  assign arr_r = arrive_mask(half_elevatorPositions[2*POS_W-1:POS_W], arrived[1]);

  // Round-robin search: walk downward so the lowest offset from ptr wins.
  always_comb begin
    int                    j;
    logic [NUM_FLOORS-1:0] pend_sh;
    j        = 0;
    pend_sh  = '0;
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      j       = (int'(ptr_q) + i) % NUM_FLOORS;
      pend_sh = pend_q >> j;
      if (pend_sh[0]) begin
        scan_hit = 1'b1;
        scan_idx = FLR_W'(j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    tgt_d    = tgt_q;
    cost_l_d = cost_l_q;
    cost_r_d = cost_r_q;
    av_d     = 1'b0;
    acar_d   = acar_q;
    afloor_d = afloor_q;
    win_r    = (cost_r_q < cost_l_q);
    tgt_mask = NUM_FLOORS'(1) << tgt_q;
    set_mask = '0;
    pend_clr = '0;

    if (run) begin
      case (state_q)
        IDLE: begin
          if (|pend_q) state_d = SCAN;
        end
        SCAN: begin
          if (scan_hit) begin
            tgt_d   = scan_idx;
            state_d = SCORE;
          end else begin
            state_d = IDLE;
          end
        end
        SCORE: begin
          cost_l_d = car_cost(pos_l, tgt_q, directions[0], |dest_q[NUM_FLOORS-1:0]);
          cost_r_d = car_cost(pos_r, tgt_q, directions[1], |dest_q[2*NUM_FLOORS-1:NUM_FLOORS]);
          state_d  = ASSIGN;
        end
        ASSIGN: begin
          set_mask = win_r ? {tgt_mask, {NUM_FLOORS{1'b0}}} : {{NUM_FLOORS{1'b0}}, tgt_mask};
          pend_clr = tgt_mask;
          av_d     = 1'b1;
          acar_d   = win_r;
          afloor_d = tgt_q;
          ptr_d    = (tgt_q == FLR_W'(NUM_FLOORS - 1)) ? '0 : tgt_q + 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Calls already owned by a car, or answered by an arrival this cycle, are absorbed.
    new_req = hall_req & ~(dest_q[NUM_FLOORS-1:0] | dest_q[2*NUM_FLOORS-1:NUM_FLOORS])
                       & ~(arr_l | arr_r);
    pend_d  = (pend_q | new_req) & ~pend_clr;
    dest_d  = (dest_q | set_mask) & ~{arr_r, arr_l};

    if (halt) begin
      state_d = IDLE;
      pend_d  = '0;
      dest_d  = '0;
      av_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      dest_q   <= '0;
      ptr_q    <= '0;
      tgt_q    <= '0;
      cost_l_q <= '0;
      cost_r_q <= '0;
      av_q     <= 1'b0;
      acar_q   <= 1'b0;
      afloor_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      dest_q   <= dest_d;
      ptr_q    <= ptr_d;
      tgt_q    <= tgt_d;
      cost_l_q <= cost_l_d;
      cost_r_q <= cost_r_d;
      av_q     <= av_d;
      acar_q   <= acar_d;
      afloor_q <= afloor_d;
    end
  end

  assign FloorDestinations = dest_q;
  assign FloorsRequested   = pend_q;
  assign assign_valid      = av_q;
  assign assign_car        = acar_q;
  assign assign_floor      = afloor_q;
  assign busy              = (state_q != IDLE);

endmodule
